// File: rtl/meas_result_reader_if.sv
// Bundle of the dpram read port and the {y,x} output stream used by meas_result_reader.
// master: the reader (drives rd_en/rd_addr and m_data/m_valid).
// slave : the memory and sink side (drives rd_data and m_ready).
interface meas_result_reader_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [2*DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready;

    modport master (
        output rd_en, rd_addr, m_data, m_valid,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_data, m_valid,
        output rd_data, m_ready
    );
endinterface

// File: rtl/meas_result_reader.sv
// meas_result_reader: drains x/y word pairs from a measurement dpram into a small
// first-word-fall-through FIFO and streams them out as {y,x} beats.
// Reads are gated by the writer's live word count and by FIFO credit, so a drain
// can overlap filling and the FIFO can never overflow.
// Optional header beat: define MEAS_RESULT_READER_HDR_EN.
module meas_result_reader #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int RDLAT   = 2,
    parameter int FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW-2:0]        len,
    input  logic [AW:0]          wr_count,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_cnt,
    meas_result_reader_if.master bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef MEAS_RESULT_READER_HDR_EN
        S_HDR,
`endif
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      last_q, last_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               rd_en_q, rd_en_d;
    logic [15:0]        frame_q, frame_d;
    logic [FIFO_AW:0]   inflight_q, inflight_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [RDLAT-1:0]   vld_q, vld_d;
    logic [RDLAT-1:0]   odd_q, odd_d;
    logic [DW-1:0]      x_hold_q, x_hold_d;
    logic [2*DW-1:0]    fifo_mem [DEPTH];

    logic               push_en;
    logic               pair_push;
    logic [2*DW-1:0]    push_word;
    logic               pop;
    logic               issue_x;
    logic               word_ready;
    logic               credit_ok;
    logic               m_valid;

    // Next-state, read issue, capture and FIFO bookkeeping; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        frame_d    = frame_q;
        x_hold_d   = x_hold_q;
        issue_x    = 1'b0;
        push_en    = 1'b0;
        pair_push  = 1'b0;
        push_word  = '0;

        word_ready = wr_count > {1'b0, addr_q};
        credit_ok  = ({1'b0, cnt_q} + {1'b0, inflight_q}) < (FIFO_AW + 2)'(DEPTH);
        pop        = (cnt_q != '0) && bus.m_ready;

        vld_d[0] = rd_en_q;
        odd_d[0] = rd_addr_q[0];
        for (int i = 1; i < RDLAT; i++) begin
            vld_d[i] = vld_q[i-1];
            odd_d[i] = odd_q[i-1];
        end

        if (vld_q[RDLAT-1]) begin
            if (odd_q[RDLAT-1]) begin
                pair_push = 1'b1;
                push_en   = 1'b1;
                push_word = {bus.rd_data, x_hold_q};
            end else begin
                x_hold_d = bus.rd_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = '0;
                    last_d = {len - (AW-1)'(1), 1'b1};
`ifdef MEAS_RESULT_READER_HDR_EN
                    state_d = S_HDR;
`else
                    state_d = S_READ;
`endif
                end
            end
`ifdef MEAS_RESULT_READER_HDR_EN
            S_HDR: begin
                push_en   = 1'b1;
                push_word = {DW'({16'hACC0, frame_q}), DW'({1'b0, last_q} + (AW+1)'(1))};
                state_d   = S_READ;
            end
`endif
            S_READ: begin
                if (word_ready && (addr_q[0] || credit_ok)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + AW'(1);
                    issue_x   = !addr_q[0];
                    if (addr_q == last_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0 && cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_d = frame_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        inflight_d = inflight_q + (FIFO_AW+1)'(issue_x) - (FIFO_AW+1)'(pair_push);
        cnt_d      = cnt_q + (FIFO_AW+1)'(push_en) - (FIFO_AW+1)'(pop);
        wptr_d     = push_en ? wptr_q + FIFO_AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + FIFO_AW'(1) : rptr_q;

        if (abort) begin
            state_d    = S_IDLE;
            rd_en_d    = 1'b0;
            vld_d      = '0;
            inflight_d = '0;
            cnt_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            push_en    = 1'b0;
            frame_d    = frame_q;
        end
    end

    // State and control registers, all returned to idle values on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            frame_q    <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            vld_q      <= '0;
            odd_q      <= '0;
            x_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            frame_q    <= frame_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            vld_q      <= vld_d;
            odd_q      <= odd_d;
            x_hold_q   <= x_hold_d;
        end
    end

    // FIFO storage; contents are only observable while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wptr_q] <= push_word;
        end
    end

    assign m_valid     = (cnt_q != '0);
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_valid ? fifo_mem[rptr_q] : '0;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign frame_cnt   = frame_q;
endmodule

// File: tb/tb_meas_result_reader.sv
// Bench for meas_result_reader: dpram model with RDLAT latency, a queue of expected
// beats built from the memory contents, and one compare process on every falling edge.
module tb_meas_result_reader;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int RDLAT = 2;
    localparam int DEPTH = 4;
`ifdef MEAS_RESULT_READER_HDR_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [10:0] len;
    logic [12:0] wr_count;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    meas_result_reader_if #(.AW(AW), .DW(DW)) bus ();

    meas_result_reader #(.AW(AW), .DW(DW), .RDLAT(RDLAT), .FIFO_AW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .wr_count  (wr_count),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];
    logic [31:0] rd_pipe [RDLAT];

    // Dpram read port model: data appears RDLAT clocks after rd_en, garbage otherwise.
    always @(posedge clk) begin
        rd_pipe[0] <= bus.rd_en ? mem[bus.rd_addr] : $urandom;
        for (int i = 1; i < RDLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.rd_data = rd_pipe[RDLAT-1];

    logic [63:0] exp_q[$];
    logic [63:0] beat_log[$];
    int          next_addr, units_issued, beats, done_seen;
    int          n_checks = 0, n_pass = 0;
    logic [15:0] exp_frame = 16'd0;
    logic [12:0] wr_target;
    bit          rand_ready = 0;
    bit          prev_hold = 0, prev_abort = 0;
    logic [63:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of the DUT against the expected-beat queue and read-order model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.rd_en) begin
                check("rd_addr", 64'(bus.rd_addr), 64'(next_addr));
                check("rd_gate", 64'(wr_count > {1'b0, bus.rd_addr}), 64'd1);
                if (bus.rd_addr[0] == 1'b0) units_issued++;
                next_addr++;
            end
            if (prev_hold && !prev_abort) check("hold", bus.m_data, prev_data);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL beat: got unexpected %h, none was due", bus.m_data);
                end else begin
                    check("beat", bus.m_data, exp_q.pop_front());
                end
                beat_log.push_back(bus.m_data);
                beats++;
            end
            check("credit", 64'(units_issued - beats <= DEPTH), 64'd1);
            if (done) begin
                done_seen++;
                check("done_last", 64'(exp_q.size()), 64'd0);
            end
            prev_hold  = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_abort = abort;
        end else begin
            prev_hold = 0;
        end
    end

    task automatic start_drain(input logic [10:0] l);
        int le;
        le = (l == 11'd0) ? 2048 : int'(l);
        exp_q.delete();
        beat_log.delete();
        for (int p = 0; p < le; p++) exp_q.push_back({mem[2*p+1], mem[2*p]});
        units_issued = 0;
`ifdef MEAS_RESULT_READER_HDR_EN
        exp_q.push_front({16'hACC0, exp_frame, 32'(le * 2)});
        units_issued = 1;
`endif
        next_addr = 0;
        beats     = 0;
        len       = l;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic finish_drain(input int budget, input string tag);
        int d0;
        bit got;
        d0  = done_seen;
        got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            cycle();
            if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
            if (wr_count < wr_target && $urandom_range(0, 1) == 1) wr_count = wr_count + 13'd1;
            if (done_seen > d0) got = 1;
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        if (got) exp_frame = exp_frame + 16'd1;
        check({tag, "_frame"}, 64'(frame_cnt), 64'(exp_frame));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_onedone"}, 64'(done_seen), 64'(d0 + 1));
        check({tag, "_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int l;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
        wr_count = '0; wr_target = '0; bus.m_ready = 1'b0;
        next_addr = 0; units_issued = 0; beats = 0; done_seen = 0;

        // Reset held with start toggling: outputs must stay at reset values.
        for (int c = 0; c < 4; c++) begin
            cycle();
            start = ~start;
            @(negedge clk);
            check("rst_rd_en", 64'(bus.rd_en), 64'd0);
            check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
            check("rst_m_valid", 64'(bus.m_valid), 64'd0);
            check("rst_m_data", bus.m_data, 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_frame", 64'(frame_cnt), 64'd0);
        end
        cycle();
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        cycle();

        // Abort together with start in idle: abort wins.
        start = 1'b1; abort = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_busy", 64'(busy), 64'd0);
        cycle();

        // Full buffer, len=4, always ready.
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i);
        wr_count = 13'd2048; wr_target = 13'd2048; bus.m_ready = 1'b1;
        start_drain(11'd4);
        finish_drain(200, "basic");
        check("basic_pair0", beat_log[HOFF], 64'h1000_0001_1000_0000);
        check("basic_beats", 64'(beats), 64'(4 + HOFF));

        // Writer stalls at 3 words, then advances to 6.
        for (int i = 0; i < 6; i++) mem[i] = $urandom;
        wr_count = 13'd3; wr_target = 13'd3;
        start_drain(11'd3);
        repeat (50) cycle();
        check("stall_pairs", 64'(beats), 64'(1 + HOFF));
        check("stall_busy", 64'(busy), 64'd1);
        wr_count = 13'd6; wr_target = 13'd6;
        finish_drain(200, "stall");

        // Sink blocked for 100 cycles: exactly one FIFO's worth outstanding.
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        wr_count = 13'd2048; wr_target = 13'd2048; bus.m_ready = 1'b0;
        start_drain(11'd16);
        repeat (100) cycle();
        @(negedge clk);
        check("bp_units", 64'(units_issued), 64'd4);
        check("bp_beats", 64'(beats), 64'd0);
        check("bp_valid", 64'(bus.m_valid), 64'd1);
        check("bp_rd_idle", 64'(bus.rd_en), 64'd0);
        cycle();
        rand_ready = 1;
        finish_drain(1000, "bp");
        rand_ready = 0;
        check("bp_total", 64'(beats), 64'(16 + HOFF));

        // Abort after 3 pairs of an 8-pair drain.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        bus.m_ready = 1'b1;
        start_drain(11'd8);
        for (int c = 0; c < 200 && beats < 3 + HOFF; c++) cycle();
        bus.m_ready = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(bus.m_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd_en", 64'(bus.rd_en), 64'd0);
        check("abort_frame", 64'(frame_cnt), 64'(exp_frame));
        cycle();
        l = done_seen;
        repeat (10) cycle();
        check("abort_no_done", 64'(done_seen), 64'(l));
        bus.m_ready = 1'b1;
        start_drain(11'd8);
        finish_drain(300, "restart");

        // Randomized drains with a writer filling concurrently and a random sink.
        rand_ready = 1;
        for (int t = 0; t < 6; t++) begin
            l = $urandom_range(1, 40);
            for (int i = 0; i < 2 * l; i++) mem[i] = $urandom;
            wr_count  = '0;
            wr_target = 13'(2 * l + $urandom_range(0, 3));
            start_drain(11'(l));
            finish_drain(3000, "rand");
        end
        rand_ready = 0;

        // len=0 drains the whole buffer up to the last address.
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        wr_count = 13'd4096; wr_target = 13'd4096; bus.m_ready = 1'b1;
        start_drain(11'd0);
        finish_drain(10000, "full");
        check("full_beats", 64'(beats), 64'(2048 + HOFF));
        check("full_last_addr", 64'(bus.rd_addr), 64'd4095);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
